// File: rtl/comparator_sweep_pkg.sv
// rtl/comparator_sweep_pkg.sv - shared types and sizing helpers for the comparator sweep stage
package comparator_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Counters must reach 2^(2*width) inclusive, hence one extra bit.
  function automatic int cnt_w(input int width);
    return 2 * width + 1;
  endfunction

endpackage

// File: rtl/compare_model.sv
// rtl/compare_model.sv - combinational reference flags for an unsigned operand pair
module compare_model
  import comparator_sweep_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             exp_less,
  output logic             exp_more,
  output logic             exp_equal,
  output logic             exp_one_bit_diff
);

  assign exp_less         = (a < b);
  assign exp_more         = (a > b);
  assign exp_equal        = (a == b);
  assign exp_one_bit_diff = ($countones(a ^ b) == 1);

endmodule

// File: rtl/comparator_sweep.sv
// rtl/comparator_sweep.sv - exhaustive comparator sweep with tallies and checking; COMPARATOR_SWEEP_DIFF_CHECK_EN adds one_bit_diff
module comparator_sweep
  import comparator_sweep_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] first_int,
  output logic [WIDTH-1:0] second_int,
  input  logic             less,
  input  logic             more,
  input  logic             equal,
  input  logic             one_bit_diff,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] less_cnt,
  output logic [CNT_W-1:0] more_cnt,
  output logic [CNT_W-1:0] equal_cnt,
`ifdef COMPARATOR_SWEEP_DIFF_CHECK_EN
  output logic [CNT_W-1:0] diff_cnt,
`endif
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_flag,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b
);

  localparam logic [WIDTH-1:0] OP_MAX = '1;

  state_t state;
  logic   m_less, m_more, m_equal, m_diff;
  logic   mismatch;

  compare_model #(.WIDTH(WIDTH)) u_model (
    .a                (first_int),
    .b                (second_int),
    .exp_less         (m_less),
    .exp_more         (m_more),
    .exp_equal        (m_equal),
    .exp_one_bit_diff (m_diff)
  );

`ifdef COMPARATOR_SWEEP_DIFF_CHECK_EN
  assign mismatch = (less != m_less) | (more != m_more) | (equal != m_equal)
                  | (one_bit_diff != m_diff);
`else
  logic unused_diff;
  assign unused_diff = one_bit_diff ^ m_diff;
  assign mismatch = (less != m_less) | (more != m_more) | (equal != m_equal);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      first_int   <= '0;
      second_int  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      less_cnt    <= '0;
      more_cnt    <= '0;
      equal_cnt   <= '0;
`ifdef COMPARATOR_SWEEP_DIFF_CHECK_EN
      diff_cnt    <= '0;
`endif
      err_cnt     <= '0;
      err_flag    <= 1'b0;
      first_err_a <= '0;
      first_err_b <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            first_int   <= '0;
            second_int  <= '0;
            busy        <= 1'b1;
            less_cnt    <= '0;
            more_cnt    <= '0;
            equal_cnt   <= '0;
`ifdef COMPARATOR_SWEEP_DIFF_CHECK_EN
            diff_cnt    <= '0;
`endif
            err_cnt     <= '0;
            err_flag    <= 1'b0;
            first_err_a <= '0;
            first_err_b <= '0;
            state       <= RUN;
          end
        end
        RUN: begin
          // Tallies follow the sampled flags, even contradictory ones.
          less_cnt  <= less_cnt + CNT_W'(less);
          more_cnt  <= more_cnt + CNT_W'(more);
          equal_cnt <= equal_cnt + CNT_W'(equal);
`ifdef COMPARATOR_SWEEP_DIFF_CHECK_EN
          diff_cnt  <= diff_cnt + CNT_W'(one_bit_diff);
`endif
          if (mismatch) begin
            err_cnt  <= err_cnt + CNT_W'(1);
            err_flag <= 1'b1;
            if (!err_flag) begin
              first_err_a <= first_int;
              first_err_b <= second_int;
            end
          end
          if (second_int == OP_MAX) begin
            second_int <= '0;
            if (first_int == OP_MAX) begin
              first_int <= '0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              first_int <= first_int + WIDTH'(1);
            end
          end else begin
            second_int <= second_int + WIDTH'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_sweep.sv
// tb/tb_comparator_sweep.sv - randomized self-checking bench for comparator_sweep
module tb_comparator_sweep;

  localparam int W  = 4;
  localparam int N  = 256;
  localparam int CW = 9;
`ifdef COMPARATOR_SWEEP_DIFF_CHECK_EN
  localparam logic [3:0] CHK = 4'hF;
`else
  localparam logic [3:0] CHK = 4'h7;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  first_int, second_int;
  logic          less, more, equal, one_bit_diff;
  logic          busy, done, err_flag;
  logic [CW-1:0] less_cnt, more_cnt, equal_cnt, diff_cnt, err_cnt;
  logic [W-1:0]  first_err_a, first_err_b;

  // Per-pair corruption applied by the bench comparator: bit0 less, bit1 more, bit2 equal, bit3 diff.
  logic [3:0] mask [N];
  logic [3:0] resp;

  int checks = 0;
  int errors = 0;
  int e_less, e_more, e_eq, e_diff, e_err, e_fa, e_fb;

  always #5 clk = ~clk;

  function automatic logic [3:0] ideal_flags(input int a, input int b);
    return {($countones(a ^ b) == 1), (a == b), (a > b), (a < b)};
  endfunction

  always_comb begin
    resp = ideal_flags(int'(first_int), int'(second_int)) ^ mask[{first_int, second_int}];
    less = resp[0];
    more = resp[1];
    equal = resp[2];
    one_bit_diff = resp[3];
  end

  comparator_sweep dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .first_int(first_int), .second_int(second_int),
    .less(less), .more(more), .equal(equal), .one_bit_diff(one_bit_diff),
    .busy(busy), .done(done),
    .less_cnt(less_cnt), .more_cnt(more_cnt), .equal_cnt(equal_cnt),
`ifdef COMPARATOR_SWEEP_DIFF_CHECK_EN
    .diff_cnt(diff_cnt),
`endif
    .err_cnt(err_cnt), .err_flag(err_flag),
    .first_err_a(first_err_a), .first_err_b(first_err_b)
  );
`ifndef COMPARATOR_SWEEP_DIFF_CHECK_EN
  assign diff_cnt = '0;
`endif

  task automatic clear_mask();
    for (int i = 0; i < N; i++) mask[i] = 4'h0;
  endtask

  // Reference: walk the pairs in sweep order and tally what the bench comparator reports.
  task automatic compute_expected();
    logic [3:0] r;
    e_less = 0; e_more = 0; e_eq = 0; e_diff = 0; e_err = 0; e_fa = 0; e_fb = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        r = ideal_flags(a, b) ^ mask[a * 16 + b];
        e_less += int'(r[0]);
        e_more += int'(r[1]);
        e_eq   += int'(r[2]);
        e_diff += int'(r[3]);
        if ((mask[a * 16 + b] & CHK) != 4'h0) begin
          if (e_err == 0) begin e_fa = a; e_fb = b; end
          e_err++;
        end
      end
    end
  endtask

  // Pulse (or hold) start and count cycles until done; busy must be high on every cycle before it.
  task automatic do_sweep(input bit hold, output int lat, output bit busy_ok);
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    while (!done && lat < 400) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({busy, done, err_flag} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {busy, done, err_flag}); end
    checks++; if ({less_cnt, more_cnt, equal_cnt, diff_cnt, err_cnt} !== '0) begin errors++; $display("FAIL reset_cnts got %0d/%0d/%0d/%0d/%0d want 0", less_cnt, more_cnt, equal_cnt, diff_cnt, err_cnt); end
    checks++; if ({first_int, second_int, first_err_a, first_err_b} !== '0) begin errors++; $display("FAIL reset_ops got %h want 0", {first_int, second_int, first_err_a, first_err_b}); end
    start = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy got %b want 0", busy); end
  endtask

  task automatic test_clean_sweep();
    int lat; bit bok;
    clear_mask(); compute_expected();
    do_sweep(1'b0, lat, bok);
    checks++; if (lat != 257) begin errors++; $display("FAIL clean_latency got %0d want 257", lat); end
    checks++; if (!bok || busy !== 1'b0) begin errors++; $display("FAIL clean_busy got ok=%0d busy_at_done=%b want ok=1 busy=0", bok, busy); end
    checks++; if (less_cnt !== 9'd120 || more_cnt !== 9'd120 || equal_cnt !== 9'd16) begin errors++; $display("FAIL clean_counts got %0d/%0d/%0d want 120/120/16", less_cnt, more_cnt, equal_cnt); end
`ifdef COMPARATOR_SWEEP_DIFF_CHECK_EN
    checks++; if (diff_cnt !== 9'd64) begin errors++; $display("FAIL clean_diff got %0d want 64", diff_cnt); end
`endif
    checks++; if (err_cnt !== 9'(e_err) || err_flag !== 1'b0) begin errors++; $display("FAIL clean_err got %0d/%b want %0d/0", err_cnt, err_flag, e_err); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL clean_done_pulse got %b want 0", done); end
  endtask

  task automatic test_fault_eq5();
    int lat; bit bok;
    clear_mask(); mask[5 * 16 + 5] = 4'b0100; compute_expected();
    do_sweep(1'b0, lat, bok);
    checks++; if (err_cnt !== 9'd1 || err_flag !== 1'b1) begin errors++; $display("FAIL eq5_err got %0d/%b want 1/1", err_cnt, err_flag); end
    checks++; if (first_err_a !== 4'd5 || first_err_b !== 4'd5) begin errors++; $display("FAIL eq5_capture got %0d,%0d want 5,5", first_err_a, first_err_b); end
    checks++; if (equal_cnt !== 9'd15 || equal_cnt !== 9'(e_eq)) begin errors++; $display("FAIL eq5_equal_cnt got %0d want 15", equal_cnt); end
  endtask

  task automatic test_start_hold();
    int lat; bit bok;
    logic [CW-1:0] snap_less, snap_err;
    clear_mask(); mask[2 * 16 + 9] = 4'b0011; compute_expected();
    do_sweep(1'b1, lat, bok);
    checks++; if (lat != 257 || !bok) begin errors++; $display("FAIL hold_latency got %0d ok=%0d want 257 ok=1", lat, bok); end
    snap_less = less_cnt; snap_err = err_cnt;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_no_restart got busy=%b want 0", busy); end
    checks++; if (less_cnt !== snap_less || less_cnt !== 9'(e_less) || err_cnt !== snap_err || err_cnt !== 9'(e_err)) begin errors++; $display("FAIL hold_totals got %0d/%0d want %0d/%0d", less_cnt, err_cnt, e_less, e_err); end
    checks++; if (first_err_a !== 4'd2 || first_err_b !== 4'd9) begin errors++; $display("FAIL hold_capture got %0d,%0d want 2,9", first_err_a, first_err_b); end
    clear_mask(); compute_expected();
    do_sweep(1'b0, lat, bok);
    checks++; if (err_cnt !== 9'd0 || err_flag !== 1'b0 || less_cnt !== 9'(e_less) || first_err_a !== 4'd0) begin errors++; $display("FAIL rerun_cleared got err=%0d flag=%b less=%0d fa=%0d want 0/0/%0d/0", err_cnt, err_flag, less_cnt, first_err_a, e_less); end
  endtask

  task automatic test_reset_mid();
    int guard = 0; bit saw_done = 1'b0;
    int lat; bit bok;
    clear_mask();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (!(first_int == 4'd7 && second_int == 4'd3) && guard < 400) begin @(negedge clk); guard++; end
    checks++; if (guard >= 400) begin errors++; $display("FAIL mid_reach_73 got timeout want pair 7,3"); end
    rst_n = 1'b0;
    #1;
    checks++; if ({less_cnt, more_cnt, equal_cnt, diff_cnt, err_cnt} !== '0 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset_cnts got %0d/%0d/%0d busy=%b want 0", less_cnt, more_cnt, equal_cnt, busy); end
    repeat (4) begin @(negedge clk); if (done) saw_done = 1'b1; end
    rst_n = 1'b1;
    repeat (4) begin @(negedge clk); if (done) saw_done = 1'b1; end
    checks++; if (saw_done) begin errors++; $display("FAIL mid_no_done got 1 want 0"); end
    compute_expected();
    do_sweep(1'b0, lat, bok);
    checks++; if (lat != 257 || less_cnt !== 9'(e_less) || more_cnt !== 9'(e_more) || equal_cnt !== 9'(e_eq) || err_cnt !== 9'd0) begin errors++; $display("FAIL mid_rerun got lat=%0d %0d/%0d/%0d err=%0d", lat, less_cnt, more_cnt, equal_cnt, err_cnt); end
  endtask

  task automatic test_diff_forced();
    int lat; bit bok; int want;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        mask[a * 16 + b] = ($countones(a ^ b) == 1) ? 4'h0 : 4'h8;
`ifdef COMPARATOR_SWEEP_DIFF_CHECK_EN
    want = 192;
`else
    want = 0;
`endif
    compute_expected();
    do_sweep(1'b0, lat, bok);
    checks++; if (err_cnt !== 9'(want) || err_cnt !== 9'(e_err)) begin errors++; $display("FAIL diff_forced_err got %0d want %0d", err_cnt, want); end
`ifdef COMPARATOR_SWEEP_DIFF_CHECK_EN
    checks++; if (diff_cnt !== 9'd256) begin errors++; $display("FAIL diff_forced_cnt got %0d want 256", diff_cnt); end
`endif
  endtask

  task automatic test_random_faults();
    int lat; bit bok;
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < N; i++)
        mask[i] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      compute_expected();
      do_sweep(1'b0, lat, bok);
      checks++; if (less_cnt !== 9'(e_less) || more_cnt !== 9'(e_more) || equal_cnt !== 9'(e_eq)) begin errors++; $display("FAIL rand%0d_counts got %0d/%0d/%0d want %0d/%0d/%0d", it, less_cnt, more_cnt, equal_cnt, e_less, e_more, e_eq); end
`ifdef COMPARATOR_SWEEP_DIFF_CHECK_EN
      checks++; if (diff_cnt !== 9'(e_diff)) begin errors++; $display("FAIL rand%0d_diff got %0d want %0d", it, diff_cnt, e_diff); end
`endif
      checks++; if (err_cnt !== 9'(e_err) || err_flag !== (e_err != 0)) begin errors++; $display("FAIL rand%0d_err got %0d/%b want %0d", it, err_cnt, err_flag, e_err); end
      checks++; if (e_err != 0 && (first_err_a !== 4'(e_fa) || first_err_b !== 4'(e_fb))) begin errors++; $display("FAIL rand%0d_capture got %0d,%0d want %0d,%0d", it, first_err_a, first_err_b, e_fa, e_fb); end
    end
  endtask

  initial begin
    clear_mask();
    test_reset();
    test_clean_sweep();
    test_fault_eq5();
    test_start_hold();
    test_reset_mid();
    test_diff_forced();
    test_random_faults();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/comparator_sweep.md
# comparator_sweep

Sequential exhaustive-sweep stage wrapped around the 4-bit magnitude comparator. It drives every operand pair into the comparator and consumes its `less`/`more`/`equal`/`one_bit_diff` outputs. It tallies each outcome and checks every response against an internal reference model. The comparator's operand inputs connect to this block's operand outputs, and the comparator's flags connect back into this block.

## Interface
Parameters:
- `WIDTH`, default 4: operand width; the sweep covers 2^(2·WIDTH) pairs.
- `CNT_W`, default 2·WIDTH+1: counter width, which holds values up to 2^(2·WIDTH) inclusive.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: begin a sweep; sampled only in IDLE.
- `first_int` out WIDTH: operand A to the comparator.
- `second_int` out WIDTH: operand B to the comparator.
- `less`, `more`, `equal`, `one_bit_diff` in 1 each: comparator responses for the pair currently driven.
- `busy` out 1: high throughout RUN.
- `done` out 1: one-cycle pulse when the sweep completes.
- `less_cnt`, `more_cnt`, `equal_cnt` out CNT_W: number of sampled pairs with that flag high.
- `diff_cnt` out CNT_W: number of pairs with `one_bit_diff` high; present only with the macro.
- `err_cnt` out CNT_W: number of pairs whose response mismatched the model.
- `err_flag` out 1: sticky; high once `err_cnt` is nonzero.
- `first_err_a`, `first_err_b` out WIDTH: operands of the first mismatching pair.

## Operation
- FSM states are IDLE, RUN and DONE.
- Reset values:
  - State is IDLE.
  - Operands are 0.
  - All counters are 0.
  - `busy`, `done` and `err_flag` are 0.
  - `first_err_a/b` are 0.
- IDLE with `start`=1:
  - Clear all counters, `err_flag` and `first_err_*`.
  - Load operands {0,0} and go to RUN.
  - Clearing and loading happen at the same edge.
- RUN, at each edge:
  - Sample the responses for the currently driven pair.
  - Increment the per-flag counters.
  - Evaluate the model and advance the pair.
- Advance order: `second_int` increments first; when it wraps from max to 0, `first_int` increments. The sequence is (0,0), (0,1) … (0,15), (1,0) … (15,15).
- Model:
  - less = A<B, more = A>B, equal = A==B (unsigned).
  - one_bit_diff = popcount(A^B)==1.
- A mismatch occurs when any checked flag differs from the model:
  - `err_cnt` increments by exactly 1 per pair, regardless of how many flags are wrong.
  - On the first mismatch, capture `first_err_a/b` and set `err_flag`.
- Responses are counted as sampled, not as expected. Contradictory responses (for example `less` and `more` both high) count in both counters and also count as an error.
- After sampling (max,max): go to DONE and return operands to 0.
- DONE lasts exactly one cycle with `done`=1, then returns to IDLE.
- Counters and error capture hold their values from DONE until the next accepted `start`.
- `start` is ignored in RUN and in DONE.
- `rst_n` asserted mid-sweep forces the reset values immediately, with no `done` pulse.

## Timing
- Operands are registered outputs. The comparator path is combinational, so responses are valid within the same cycle and are sampled at the following edge.
- Throughput is one pair per cycle.
- `start` is accepted at edge k. `busy` is high from cycle k+1 through cycle k+2^(2·WIDTH).
- `done` is high in cycle k+2^(2·WIDTH)+1; this is 257 cycles after the start edge for WIDTH=4.
- Final counter values are stable and readable in the `done` cycle.
- No combinational path exists from any input to any output.

## Configuration
- Macro: `COMPARATOR_SWEEP_DIFF_CHECK_EN`.
- Defined:
  - The `diff_cnt` port exists.
  - `one_bit_diff` is counted and included in the mismatch check.
- Undefined:
  - The `diff_cnt` port and its counter are absent.
  - The `one_bit_diff` input is ignored, and only less/more/equal are checked.

## Structure
- Package `comparator_sweep_pkg` contains:
  - The state enum (IDLE, RUN, DONE).
  - The default WIDTH constant.
  - A `CNT_W` helper function.
- Sub-module `compare_model` computes the expected less/more/equal/one_bit_diff combinationally from A and B. It is instantiated once.

## Test plan
- **Reset:** `rst_n`=0 with no `start` → all outputs 0 and `busy`=0; assert `start`=1 while in reset → no effect.
- **Correct comparator, WIDTH=4:** pulse `start` → `done` pulses 257 cycles later with:
  - `less_cnt`=120, `more_cnt`=120, `equal_cnt`=16
  - `diff_cnt`=64 (with the macro)
  - `err_cnt`=0, `err_flag`=0
- **Fault injection:** bench forces `equal`=0 when A=B=5 → `err_cnt`=1, `first_err_a`=5, `first_err_b`=5, `err_flag`=1, `equal_cnt`=15.
- **Start during operation:** `start` held high during RUN and in the DONE cycle → the sweep is not restarted and the totals are unchanged. A `start` pulse after returning to IDLE clears the counters and reruns the sweep.
- **Reset mid-sweep:** assert `rst_n` low at pair (7,3) → all counters are 0 immediately, with no `done` pulse. A subsequent `start` runs a full sweep with the correct totals.
- **Macro undefined:** force `one_bit_diff` to a constant 1 → `err_cnt`=0; with the macro defined the same stimulus gives `err_cnt`=192.
